// File: rtl/sat_load_ctrl_pkg.sv
// Shared types and sizing for the SAT load/solve controller slice.
// No logic and no latency of its own.
// Backpressure: not applicable.
package common;

    localparam int number_literal = 5;
    localparam int number_clause  = 10;

    // One clause occupies two words: positive-literal mask, then negative-literal mask.
    typedef logic [number_literal-1:0] clause_word_t;
    typedef clause_word_t [2*number_clause-1:0] formula_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_WAIT_RS,
        ST_SOLVE_GO,
        ST_SOLVE_WAIT,
        ST_DONE
    } ctrl_state_t;

endpackage

// File: rtl/sat_load_ctrl_watchdog.sv
// Solve watchdog: counts SOLVE_WAIT cycles and flags expiry after TIMEOUT_CYC of them.
// Latency: expired is combinational on the TIMEOUT_CYC-th enabled cycle after clr.
// Backpressure: none; the counter freezes at the limit until cleared.
// Ports: clock, reset (async active-low), clr (restart count), en (count this cycle),
//        expired (limit reached this cycle).
// Only compiled when SAT_LOAD_CTRL_TIMEOUT_EN is defined.
`ifdef SAT_LOAD_CTRL_TIMEOUT_EN
module sat_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] cnt;

    // cnt holds the number of enabled cycles already elapsed, so the current
    // cycle is the last allowed one when cnt == TIMEOUT_CYC-1.
    assign expired = en && (cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule
`endif

// File: rtl/sat_load_ctrl.sv
// Sequencer for one SAT solve: stream clause words into read_store, zero-pad, run the solver, latch result.
// Latency: host words pass to rs_load/rs_lit combinationally; solve_start one cycle after rs_ended seen; done one cycle after solve_done.
// Backpressure: in_ready drops once WORDS words are taken or outside LOAD; host must hold in_valid/in_data until accepted.
// Ports: clock/reset (async active-low); start; host in_valid/in_ready/in_data/in_last;
//        read_store rs_load/rs_lit/rs_ended; solver solve_start/solve_done/solve_sat/solve_model;
//        status busy/done/sat/model/err_odd/timeout.
// Optional watchdog enabled by defining SAT_LOAD_CTRL_TIMEOUT_EN; otherwise timeout stays 0.
module sat_load_ctrl
    import common::*;
#(
    parameter int NUM_LIT     = number_literal,
    parameter int NUM_CLAUSE  = number_clause,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_LIT-1:0] in_data,
    input  logic               in_last,
    output logic               rs_load,
    output logic [NUM_LIT-1:0] rs_lit,
    input  logic               rs_ended,
    output logic               solve_start,
    input  logic               solve_done,
    input  logic               solve_sat,
    input  logic [NUM_LIT-1:0] solve_model,
    output logic               busy,
    output logic               done,
    output logic               sat,
    output logic [NUM_LIT-1:0] model,
    output logic               err_odd,
    output logic               timeout
);

    localparam int WORDS = 2 * NUM_CLAUSE;
    localparam int CW    = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    ctrl_state_t   state;
    logic [CW-1:0] word_cnt;
    logic          xfer;
    logic          wd_expired;

    // Host words go straight through to read_store in the accepting cycle;
    // PAD strobes zero words with no host involvement.
    always_comb begin
        in_ready = (state == ST_LOAD) && (word_cnt < CW'(WORDS));
        xfer     = in_valid && in_ready;
        rs_load  = xfer || (state == ST_PAD);
        rs_lit   = xfer ? in_data : '0;
    end

`ifdef SAT_LOAD_CTRL_TIMEOUT_EN
    sat_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clr     (state == ST_SOLVE_GO),
        .en      (state == ST_SOLVE_WAIT),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            solve_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sat         <= 1'b0;
            model       <= '0;
            err_odd     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            solve_start <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        sat      <= 1'b0;
                        model    <= '0;
                        err_odd  <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_IDX) begin
                            // Capacity reached, with or without in_last.
                            state <= ST_WAIT_RS;
                        end else if (in_last) begin
                            state   <= ST_PAD;
                            // word_cnt+1 is odd exactly when word_cnt is even:
                            // the stream stopped after a pos-mask word.
                            err_odd <= ~word_cnt[0];
                        end
                    end
                end
                ST_PAD: begin
                    word_cnt <= word_cnt + 1'b1;
                    if (word_cnt == LAST_IDX) begin
                        state <= ST_WAIT_RS;
                    end
                end
                ST_WAIT_RS: begin
                    if (rs_ended) begin
                        state       <= ST_SOLVE_GO;
                        solve_start <= 1'b1;
                    end
                end
                ST_SOLVE_GO: begin
                    // A solve_done seen alongside the start pulse is stale.
                    state <= ST_SOLVE_WAIT;
                end
                ST_SOLVE_WAIT: begin
                    if (solve_done) begin
                        state <= ST_DONE;
                        sat   <= solve_sat;
                        model <= solve_model;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (wd_expired) begin
                        state   <= ST_DONE;
                        sat     <= 1'b0;
                        model   <= '0;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sat_load_ctrl.md
Name: sat_load_ctrl

Overview:
- Top-level sequencer for one SAT solve: accepts clause words from a host stream (valid/ready) and strobes them into read_store.
- Zero-pads an unfilled formula, waits for read_store's ended flag, then runs the solver core with a start/done handshake.
- Latches the SAT verdict and model, and sits between host interface, read_store and solver engine.

Parameters:
- NUM_LIT, common::number_literal (5), literal mask width (bits per clause word).
- NUM_CLAUSE, common::number_clause (10), clause capacity; total words WORDS = 2*NUM_CLAUSE.
- TIMEOUT_CYC, 4096, solve watchdog limit (used only with the optional feature).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load/solve run; ignored while busy.
- in_valid  in  1  host word valid.
- in_ready  out  1  controller accepts word this cycle.
- in_data  in  NUM_LIT  clause word; pos mask then neg mask per clause.
- in_last  in  1  marks the final host word of the formula.
- rs_load  out  1  word strobe to read_store (one word per high cycle).
- rs_lit  out  NUM_LIT  word to read_store.
- rs_ended  in  1  read_store finished storing the formula.
- solve_start  out  1  one-cycle pulse to solver core.
- solve_done  in  1  solver finished (level or pulse).
- solve_sat  in  1  solver verdict, valid with solve_done.
- solve_model  in  NUM_LIT  satisfying assignment, valid with solve_done.
- busy  out  1  run in progress.
- done  out  1  result valid; held until next accepted start.
- sat  out  1  latched verdict.
- model  out  NUM_LIT  latched assignment.
- err_odd  out  1  in_last arrived on a pos-mask word (odd count).
- timeout  out  1  watchdog fired (0 without the optional feature).

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, word_cnt 0.
- States: IDLE, LOAD, PAD, WAIT_RS, SOLVE_GO, SOLVE_WAIT, DONE.
- IDLE/DONE + start: clear done/sat/model/err_odd/timeout and word_cnt; go LOAD; busy=1 next cycle.
- LOAD: in_ready=1 iff word_cnt<WORDS.
  - Transfer (in_valid&in_ready): rs_load=1 and rs_lit=in_data in the same cycle (combinational pass-through); word_cnt++.
  - No transfer cycle: rs_load=0, rs_lit=0.
- LOAD exit:
  - Transfer with in_last and word_cnt+1==WORDS -> WAIT_RS.
  - Transfer with in_last and fewer words -> PAD; err_odd=1 if word_cnt+1 is odd.
  - word_cnt reaches WORDS without in_last -> WAIT_RS; later host words are not accepted.
- PAD: in_ready=0; rs_load=1, rs_lit=0 every cycle until word_cnt==WORDS, then WAIT_RS. An odd-count tail is thereby completed as a positive-only clause.
- WAIT_RS: all strobes low; wait for rs_ended=1 -> SOLVE_GO.
- SOLVE_GO: solve_start=1 for exactly one cycle -> SOLVE_WAIT.
- SOLVE_WAIT: on solve_done=1, latch sat<=solve_sat and model<=solve_model -> DONE. solve_done coinciding with solve_start is ignored.
- DONE: busy=0, done=1. A start pulse re-enters LOAD immediately.
- start while busy: ignored, no effect.
- Async reset mid-run: abort to IDLE; read_store/solver are reset by the same net.

Optional Feature:
- Macro SAT_LOAD_CTRL_TIMEOUT_EN.
- Defined: counter of width $clog2(TIMEOUT_CYC+1), cleared on entering SOLVE_WAIT. After TIMEOUT_CYC cycles without solve_done -> DONE with timeout=1, sat=0, model=0. solve_done on the expiry cycle wins (normal latch, timeout=0).
- Undefined: no counter; SOLVE_WAIT waits indefinitely; timeout tied 0.

Decomposition:
- Package common holds number_literal, number_clause, formula type, and a new state enum ctrl_state_t.
- One sub-module, sat_watchdog (counter plus expiry flag), instantiated only under the macro.

Test Plan:
- Full 20-word stream (e.g. 11100,00000,...,00000) with continuous valid, in_last on word 20 -> 20 rs_load cycles with matching rs_lit, no PAD, solve_start once after rs_ended.
- 14 words (abc / a'b'c' / d'e / a'd / bc / abc'de / bde'), in_last on word 14 -> 6 PAD cycles rs_lit=00000, word_cnt=20, err_odd=0.
- in_last on word 3 (valid toggled 1,0,1,0,1) -> rs_load only on accepted cycles, then 17 zero pads, err_odd=1.
- Solver stub returns solve_done after 5 cycles with sat=1, model=10110 -> done=1, sat=1, model=10110 held; start pulse during SOLVE_WAIT ignored.
- Reset asserted mid-PAD -> all outputs 0 immediately; next start runs cleanly from word_cnt 0.
- Macro defined, TIMEOUT_CYC=8, solver never responds -> timeout=1, done=1, sat=0 exactly 8 cycles after SOLVE_WAIT entry.
